// File: rtl/reverb_ctrl_pkg.sv
// Shared types and sizing helpers for the reverb tap-reload controller.
package reverb_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        DISABLE,
        LOAD,
        WAIT_DONE
    } state_e;

    localparam int DEFAULT_NUM_TAPS = 16;

    function automatic int tap_count(input int num_taps_log2);
        return 1 << num_taps_log2;
    endfunction

    // Width able to hold (cycles-1) for the longer of the two wait phases.
    function automatic int counter_width(input int drain_cycles, input int disable_cycles);
        int longest;
        int width;
        longest = (drain_cycles > disable_cycles) ? drain_cycles : disable_cycles;
        width   = $clog2(longest);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/tap_shadow_ram.sv
// Software-writable shadow bank of FIR taps; contents survive reset.
module tap_shadow_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read is combinational; the sequencer registers it into its tap output.
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/reverb_tap_sequencer.sv
// Quiesces the reverb input, clears the engine, streams the shadow taps into it
// and re-enables it whenever software commits a new tap set.
module reverb_tap_sequencer
    import reverb_ctrl_pkg::*;
#(
    parameter int G_NUM_TAPS_LOG2  = $clog2(DEFAULT_NUM_TAPS),
    parameter int G_TAP_WIDTH      = 16,
    parameter int G_DRAIN_CYCLES   = 32,
    parameter int G_DISABLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_wr_en,
    input  logic [G_NUM_TAPS_LOG2-1:0] cfg_wr_addr,
    input  logic [G_TAP_WIDTH-1:0]     cfg_wr_data,
    output logic                       cfg_wr_ready,
    input  logic                       commit,
    output logic                       busy,
    output logic                       loaded,
    output logic                       commit_pending,
    output logic                       core_enable,
    output logic                       input_hold,
    output logic [G_TAP_WIDTH-1:0]     tap_dout,
    output logic                       tap_dout_valid,
    input  logic                       tap_dout_ready,
    input  logic                       tap_done
);

    localparam int NUM_TAPS = tap_count(G_NUM_TAPS_LOG2);
    localparam int CNT_W    = counter_width(G_DRAIN_CYCLES, G_DISABLE_CYCLES);
    localparam int IDX_W    = G_NUM_TAPS_LOG2 + 1;
    localparam int AW       = G_NUM_TAPS_LOG2;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       idx_inc;
    logic                   loaded_q, loaded_d;
    logic                   pending_q, pending_d;
    logic [G_TAP_WIDTH-1:0] tap_q, tap_d;
    logic                   tap_valid_q, tap_valid_d;

    logic                   wr_take;
    logic [AW-1:0]          rd_addr;
    logic [G_TAP_WIDTH-1:0] rd_data;
    logic [G_TAP_WIDTH-1:0] rd_word;

    assign wr_take = cfg_wr_en && cfg_wr_ready;
    assign idx_inc = idx_q + 1'b1;

    // Outside LOAD the next word to fetch is always tap 0.
    assign rd_addr = (state_q == LOAD) ? idx_inc[AW-1:0] : '0;

    // A write landing in the last DISABLE cycle must still reach the stream.
    assign rd_word = (wr_take && (cfg_wr_addr == rd_addr)) ? cfg_wr_data : rd_data;

    tap_shadow_ram #(
        .ADDR_W (AW),
        .DATA_W (G_TAP_WIDTH)
    ) u_shadow (
        .clk     (clk),
        .wr_en   (wr_take),
        .wr_addr (cfg_wr_addr),
        .wr_data (cfg_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            loaded_q    <= 1'b0;
            pending_q   <= 1'b0;
            tap_q       <= '0;
            tap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            loaded_q    <= loaded_d;
            pending_q   <= pending_d;
            tap_q       <= tap_d;
            tap_valid_q <= tap_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        loaded_d    = loaded_q;
        pending_d   = pending_q;
        tap_d       = tap_q;
        tap_valid_d = tap_valid_q;

        if (commit && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (commit || pending_q) begin
                    state_d   = DRAIN;
                    pending_d = 1'b0;
                    cnt_d     = CNT_W'(G_DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = DISABLE;
                    cnt_d   = CNT_W'(G_DISABLE_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DISABLE: begin
                if (cnt_q == '0) begin
                    state_d     = LOAD;
                    idx_d       = '0;
                    tap_d       = rd_word;
                    tap_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOAD: begin
                if (tap_valid_q && tap_dout_ready) begin
                    // Carry into the top index bit marks the last accepted tap.
                    if (idx_inc[AW]) begin
                        tap_valid_d = 1'b0;
                        state_d     = WAIT_DONE;
                    end else begin
                        idx_d = idx_inc;
                        tap_d = rd_word;
                    end
                end
            end
            WAIT_DONE: begin
                if (tap_done) begin
                    loaded_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        core_enable = loaded_q;
        case (state_q)
            DISABLE:         core_enable = 1'b0;
            LOAD, WAIT_DONE: core_enable = 1'b1;
            default:         core_enable = loaded_q;
        endcase
    end

    // A pending commit keeps the audio gated across back-to-back reloads.
    assign input_hold     = (state_q != IDLE) || !loaded_q || pending_q;
    assign busy           = (state_q != IDLE);
    assign cfg_wr_ready   = (state_q != LOAD);
    assign loaded         = loaded_q;
    assign commit_pending = pending_q;
    assign tap_dout       = tap_q;
    assign tap_dout_valid = tap_valid_q;

    // Only referenced to size the package-derived index width.
    if (NUM_TAPS != (1 << AW)) begin : g_bad_tap_count
        $error("tap count does not match index width");
    end

endmodule

// File: tb/tb_reverb_tap_sequencer.sv
// Scoreboard bench for the reverb tap-reload controller.
module tb_reverb_tap_sequencer;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_wr_en;
    logic [3:0]  cfg_wr_addr;
    logic [15:0] cfg_wr_data;
    logic        cfg_wr_ready;
    logic        commit;
    logic        busy;
    logic        loaded;
    logic        commit_pending;
    logic        core_enable;
    logic        input_hold;
    logic [15:0] tap_dout;
    logic        tap_dout_valid;
    logic        tap_dout_ready;
    logic        tap_done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          beat_cnt = 0;
    int          beat_start = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model [N];
    bit          rand_mode = 1'b0;

    always #5 clk = ~clk;

    reverb_tap_sequencer #(
        .G_NUM_TAPS_LOG2  (4),
        .G_TAP_WIDTH      (16),
        .G_DRAIN_CYCLES   (32),
        .G_DISABLE_CYCLES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_wr_addr    (cfg_wr_addr),
        .cfg_wr_data    (cfg_wr_data),
        .cfg_wr_ready   (cfg_wr_ready),
        .commit         (commit),
        .busy           (busy),
        .loaded         (loaded),
        .commit_pending (commit_pending),
        .core_enable    (core_enable),
        .input_hold     (input_hold),
        .tap_dout       (tap_dout),
        .tap_dout_valid (tap_dout_valid),
        .tap_dout_ready (tap_dout_ready),
        .tap_done       (tap_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Ready driver: constant 1, or a rotating directed stall pattern.
    initial begin
        logic [31:0] pat;
        pat = 32'hB4D2_69A5;
        tap_dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                tap_dout_ready = pat[0];
                pat = {pat[0], pat[31:1]};
            end else begin
                tap_dout_ready = 1'b1;
            end
        end
    end

    // Monitor: pops and compares on every handshake, checks stability under stall.
    initial begin
        bit          stalled;
        logic [15:0] held;
        logic [15:0] want;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (stalled) begin
                check("stall_valid", 32'(tap_dout_valid), 32'd1);
                check("stall_hold", 32'(tap_dout), 32'(held));
            end
            stalled = 1'b0;
            if (tap_dout_valid && tap_dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got 0x%0h required no beat", tap_dout);
                end else begin
                    want = exp_q.pop_front();
                    check($sformatf("beat%0d", beat_cnt - beat_start), 32'(tap_dout), 32'(want));
                end
                beat_cnt++;
            end else if (tap_dout_valid) begin
                stalled = 1'b1;
                held    = tap_dout;
            end
        end
    end

    task automatic write_tap(input logic [3:0] addr, input logic [15:0] data);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = addr;
        cfg_wr_data = data;
        model[addr] = data;
        @(negedge clk);
        cfg_wr_en   = 1'b0;
    endtask

    // Drain / disable timeline up to the first LOAD cycle.
    task automatic seq_timing(input bit do_commit, input bit exp_loaded, input bit do_wr,
                              input logic [3:0] wa, input logic [15:0] wd);
        if (do_commit) begin
            commit = 1'b1;
            @(negedge clk);
            commit = 1'b0;
        end else begin
            @(negedge clk);
        end
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            check("drain_busy", 32'(busy), 32'd1);
            check("drain_hold", 32'(input_hold), 32'd1);
            check("drain_enable", 32'(core_enable), 32'(exp_loaded));
            if (k == 0) check("drain_pending_clr", 32'(commit_pending), 32'd0);
            if (do_wr && k == 10) begin
                cfg_wr_en   = 1'b1;
                cfg_wr_addr = wa;
                cfg_wr_data = wd;
                model[wa]   = wd;
            end
            if (k == 11) cfg_wr_en = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            check("disable_enable", 32'(core_enable), 32'd0);
            check("disable_valid", 32'(tap_dout_valid), 32'd0);
            check("disable_hold", 32'(input_hold), 32'd1);
            if (d == 0) begin
                beat_start = beat_cnt;
                for (int i = 0; i < N; i++) exp_q.push_back(model[i]);
            end
        end
        @(negedge clk);
        check("load_valid", 32'(tap_dout_valid), 32'd1);
        check("load_enable", 32'(core_enable), 32'd1);
        check("load_wr_ready", 32'(cfg_wr_ready), 32'd0);
    endtask

    task automatic wait_beats(input bit do_mid);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i > 0) @(negedge clk);
            if (do_mid && i == 3) begin
                check("mid_wr_ready", 32'(cfg_wr_ready), 32'd0);
                cfg_wr_en   = 1'b1;
                cfg_wr_addr = 4'd3;
                cfg_wr_data = 16'hBEEF;
                commit      = 1'b1;
            end
            if (do_mid && i == 4) begin
                cfg_wr_en = 1'b0;
                commit    = 1'b0;
                check("pending_set", 32'(commit_pending), 32'd1);
            end
            if (exp_q.size() == 0 && !tap_dout_valid) begin
                done = 1'b1;
                break;
            end
        end
        check("beats_timeout", 32'(done), 32'd1);
        check("beat_count", 32'(beat_cnt - beat_start), 32'd16);
    endtask

    task automatic finish_done(input bit exp_pending);
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_valid", 32'(tap_dout_valid), 32'd0);
        check("wait_hold", 32'(input_hold), 32'd1);
        tap_done = 1'b1;
        @(negedge clk);
        tap_done = 1'b0;
        check("done_loaded", 32'(loaded), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_hold", 32'(input_hold), 32'(exp_pending));
        check("done_pending", 32'(commit_pending), 32'(exp_pending));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        cfg_wr_en   = 1'b0;
        cfg_wr_addr = '0;
        cfg_wr_data = '0;
        commit      = 1'b0;
        tap_done    = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_loaded", 32'(loaded), 32'd0);
        check("rst_pending", 32'(commit_pending), 32'd0);
        check("rst_enable", 32'(core_enable), 32'd0);
        check("rst_hold", 32'(input_hold), 32'd1);
        check("rst_valid", 32'(tap_dout_valid), 32'd0);
        check("rst_dout", 32'(tap_dout), 32'd0);
        check("rst_wr_ready", 32'(cfg_wr_ready), 32'd1);

        // Basic load of 0x0000..0x0F00
        for (int i = 0; i < N; i++) write_tap(4'(i), 16'(i * 16'h0100));
        seq_timing(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
        wait_beats(1'b0);
        finish_done(1'b0);

        // Stalling ready
        for (int i = 0; i < N; i++) write_tap(4'(i), 16'(16'h1000 + i * 16'h0111));
        rand_mode = 1'b1;
        seq_timing(1'b1, 1'b1, 1'b0, 4'd0, 16'd0);
        wait_beats(1'b0);
        finish_done(1'b0);
        rand_mode = 1'b0;
        @(negedge clk);

        // Drain-phase write, dropped LOAD write, commit during LOAD
        seq_timing(1'b1, 1'b1, 1'b1, 4'd5, 16'h7FFF);
        wait_beats(1'b1);
        finish_done(1'b1);
        seq_timing(1'b0, 1'b1, 1'b0, 4'd0, 16'd0);
        wait_beats(1'b0);
        finish_done(1'b0);

        // Reset during beat 7
        seq_timing(1'b1, 1'b1, 1'b0, 4'd0, 16'd0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_valid", 32'(tap_dout_valid), 32'd0);
        check("mrst_enable", 32'(core_enable), 32'd0);
        check("mrst_hold", 32'(input_hold), 32'd1);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_loaded", 32'(loaded), 32'd0);
        check("mrst_beats_seen", 32'(beat_cnt - beat_start), 32'd8);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);

        // tap_done held low
        seq_timing(1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
        wait_beats(1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_hold", 32'(input_hold), 32'd1);
        end
        finish_done(1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reverb_tap_sequencer.md
Name: reverb_tap_sequencer

Overview:
- Controller for the reverb datapath: the FIR-with-feedback reverb engine and its `configurable_fir` core.
- Holds a software-writable shadow bank of FIR taps.
- On a commit request it quiesces the reverb input, clears the engine by dropping its enable, streams the shadow taps into the engine's tap port, then re-enables the engine and releases the audio input.
- Sits between the register block and the reverb wrapper; its outputs drive the wrapper's enable, tap stream and an input-gate on the audio din_valid.

Parameters:
- G_NUM_TAPS_LOG2, 4, log2 of tap count; equals G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2 of the FIR.
- G_TAP_WIDTH, 16, tap word width.
- G_DRAIN_CYCLES, 32, cycles to hold input off before disabling the engine (≥ FIR pipeline depth + 2).
- G_DISABLE_CYCLES, 2, cycles engine enable is held low to clear state.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_wr_en  in  1  shadow tap write strobe
- cfg_wr_addr  in  G_NUM_TAPS_LOG2  shadow tap index
- cfg_wr_data  in  G_TAP_WIDTH  tap value
- cfg_wr_ready  out  1  shadow writable; a write is taken only when cfg_wr_en and cfg_wr_ready
- commit  in  1  single-cycle pulse requesting a reload
- busy  out  1  reload sequence in progress
- loaded  out  1  at least one reload has completed since reset
- commit_pending  out  1  a commit was latched while busy
- core_enable  out  1  to reverb wrapper enable
- input_hold  out  1  high = upstream must gate din_valid to 0
- tap_dout  out  G_TAP_WIDTH  to wrapper tap_din
- tap_dout_valid  out  1  to wrapper tap_din_valid
- tap_dout_ready  in  1  from wrapper tap_din_ready
- tap_done  in  1  from wrapper tap_din_done

Behaviour:
- Reset values:
  - state IDLE; busy=0, loaded=0, commit_pending=0.
  - core_enable=0, input_hold=1, tap_dout_valid=0, tap_dout=0, cfg_wr_ready=1.
  - Shadow bank contents are not reset.
- Reset mid-sequence: aborts immediately to the reset values; the tap stream is abandoned with no further valid.
- States and transitions:
  - IDLE: busy=0. On commit (or commit_pending set), go to DRAIN next cycle, clear commit_pending, load the counter with G_DRAIN_CYCLES-1, set input_hold=1.
    - core_enable=loaded.
    - input_hold=!loaded, so audio stays blocked until the first load.
  - DRAIN: input_hold=1, core_enable unchanged. Counter decrements; at 0 go to DISABLE with the counter set to G_DISABLE_CYCLES-1.
  - DISABLE: core_enable=0. Counter decrements; at 0 go to LOAD with tap index 0.
  - LOAD: core_enable=1, cfg_wr_ready=0.
    - tap_dout/tap_dout_valid are registered. tap_dout=shadow[index] is presented with valid=1; the value is held stable while valid && !ready.
    - On valid && ready, index increments and the next word is presented the following cycle with no bubble.
    - After index 2^G_NUM_TAPS_LOG2-1 is accepted, valid drops and the state becomes WAIT_DONE.
  - WAIT_DONE: wait for tap_done=1, then loaded←1, input_hold←0, state IDLE.
- Tap order: index 0 first, ascending.
- cfg_wr_ready=0 only in LOAD. Writes in IDLE/DRAIN/DISABLE/WAIT_DONE update the bank; a write in DRAIN/DISABLE is included in the current load.
- commit while busy: sets commit_pending (sticky, idempotent). On return to IDLE it starts a new sequence the next cycle; input_hold stays 1 across the back-to-back sequences.
- commit in the same cycle as the WAIT_DONE→IDLE transition is latched as pending.
- busy = (state != IDLE).
- No arithmetic beyond the counters. Counter width is clog2(max(G_DRAIN_CYCLES,G_DISABLE_CYCLES)); index width is G_NUM_TAPS_LOG2+1 to detect wrap.

Decomposition:
- Package reverb_ctrl_pkg:
  - typedef enum for the states (IDLE, DRAIN, DISABLE, LOAD, WAIT_DONE).
  - constant for tap count.
  - function to compute counter width.
- One natural sub-module: tap_shadow_ram (write port from cfg, read port by index, combinational read registered into tap_dout).

Test Plan:
1. Reset, write taps 0..15 = 0x0100*i, commit:
   - input_hold high, core_enable 0 for exactly 2 cycles after 32 drain cycles.
   - 16 beats 0x0000..0x0F00 in order.
   - tap_done → loaded=1, input_hold=0 on the next cycle.
2. Same as 1 with tap_dout_ready toggling 1/0 randomly:
   - tap_dout stable while stalled; no beat lost or duplicated; beat count 16.
3. Commit pulsed during LOAD:
   - commit_pending=1.
   - After the first tap_done, IDLE lasts 1 cycle, then DRAIN restarts.
   - input_hold never deasserts between the two sequences.
4. Write during LOAD:
   - cfg_wr_ready=0 and the write is dropped.
   - Write addr 5=0x7FFF during DRAIN → beat 5 carries 0x7FFF.
5. Assert reset during beat 7 of LOAD:
   - Next cycle tap_dout_valid=0, core_enable=0, input_hold=1, busy=0, loaded=0.
6. tap_done held low:
   - The block stays in WAIT_DONE with busy=1 and input_hold=1 indefinitely.
   - Asserting tap_done releases it.
